// File: rtl/clock_set_pkg.sv
// clock_set_pkg: shared states, field codes and range limits for the time-set controller
package clock_set_pkg;
    typedef enum logic [2:0] {ST_RUN, ST_EDIT_H, ST_EDIT_M, ST_EDIT_S, ST_COMMIT} state_t;
    localparam logic [1:0] FLD_NONE = 2'b00;
    localparam logic [1:0] FLD_HOUR = 2'b01;
    localparam logic [1:0] FLD_MIN  = 2'b10;
    localparam logic [1:0] FLD_SEC  = 2'b11;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;
    localparam logic [SEC_W-1:0] SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX  = 6'd59;
    localparam logic [HR_W-1:0]  HR24_MAX = 5'd23;
    localparam logic [HR_W-1:0]  HR12_MAX = 5'd11;
endpackage

// File: rtl/time_field_step.sv
// time_field_step: wrap-around increment/decrement of one time field; inc and dec together cancel
module time_field_step (
    input  logic [5:0] value,
    input  logic [5:0] max,
    input  logic       inc,
    input  logic       dec,
    output logic [5:0] nxt
);
    assign nxt = (inc && !dec) ? ((value >= max) ? 6'd0 : value + 6'd1) :
                 (dec && !inc) ? ((value == 6'd0) ? max : value - 6'd1) : value;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven hour/minute/second edit with preset load and inactivity timeout
// Optional CLOCK_SET_AUTO_REPEAT_EN adds hold-to-repeat stepping on inc/dec.
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 10,
    parameter int REPEAT_DLY    = 500,
    parameter int REPEAT_RATE   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] cur_s,
    input  logic [5:0] cur_m,
    input  logic [4:0] cur_h,
    output logic [5:0] set_s,
    output logic [5:0] set_m,
    output logic [4:0] set_h,
    output logic       load,
    output logic       editing,
    output logic [1:0] field,
    output logic       blink
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    state_t          state_q, state_d;
    logic [4:0]      set_h_q, set_h_d;
    logic [5:0]      set_m_q, set_m_d, set_s_q, set_s_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            blink_q, blink_d;
    logic            btn_set_q, btn_inc_q, btn_dec_q;
    logic            press_set, press_inc, press_dec, rep_inc, rep_dec;
    logic [5:0]      fval, fmax, fnxt;
    logic            edit_next;

    assign press_set = btn_set & ~btn_set_q;
    assign press_inc = btn_inc & ~btn_inc_q;
    assign press_dec = btn_dec & ~btn_dec_q;

    assign editing = state_q == ST_EDIT_H || state_q == ST_EDIT_M || state_q == ST_EDIT_S;
    assign field   = state_q == ST_EDIT_H ? FLD_HOUR : state_q == ST_EDIT_M ? FLD_MIN :
                     state_q == ST_EDIT_S ? FLD_SEC : FLD_NONE;
    assign load    = state_q == ST_COMMIT;
    assign set_h   = set_h_q;
    assign set_m   = set_m_q;
    assign set_s   = set_s_q;
    assign blink   = blink_q;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int RL = REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW = $clog2(RL + 1);
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          armed_q, armed_d, alone, fire;
    assign alone   = btn_inc ^ btn_dec;
    assign fire    = alone && rcnt_q == (armed_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DLY));
    assign rep_inc = editing && fire && btn_inc;
    assign rep_dec = editing && fire && btn_dec;
    // hold counter: first step after REPEAT_DLY, then one every REPEAT_RATE until release
    always_comb begin
        rcnt_d  = !alone ? '0 : fire ? RW'(1) : rcnt_q + RW'(1);
        armed_d = alone && (armed_q || fire);
    end
    // repeat counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            rcnt_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            rcnt_q  <= rcnt_d;
            armed_q <= armed_d;
        end
    end
`else
    assign rep_inc = 1'b0;
    assign rep_dec = 1'b0;
`endif

    assign fval = state_q == ST_EDIT_H ? {1'b0, set_h_q} : state_q == ST_EDIT_M ? set_m_q : set_s_q;
    assign fmax = state_q == ST_EDIT_H ? {1'b0, mode ? HR12_MAX : HR24_MAX} :
                  state_q == ST_EDIT_M ? MIN_MAX : SEC_MAX;

    time_field_step u_step (
        .value (fval),
        .max   (fmax),
        .inc   (press_inc | rep_inc),
        .dec   (press_dec | rep_dec),
        .nxt   (fnxt)
    );

    // next state, edit registers and timeout; a set press takes precedence over any step
    always_comb begin
        state_d = state_q;
        set_h_d = set_h_q;
        set_m_d = set_m_q;
        set_s_d = set_s_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_RUN: begin
                if (press_set) begin
                    state_d = ST_EDIT_H;
                    set_h_d = (mode && cur_h > HR12_MAX) ? cur_h - 5'd12 : cur_h;
                    set_m_d = cur_m;
                    set_s_d = cur_s;
                    tcnt_d  = '0;
                end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (press_set)
                    state_d = state_q == ST_EDIT_H ? ST_EDIT_M : state_q == ST_EDIT_M ? ST_EDIT_S : ST_COMMIT;
                else if (state_q == ST_EDIT_H)
                    set_h_d = fnxt[4:0];
                else if (state_q == ST_EDIT_M)
                    set_m_d = fnxt;
                else
                    set_s_d = fnxt;
                if (mode && set_h_q > HR12_MAX)
                    set_h_d = '0;
                if (press_set || press_inc || press_dec || rep_inc || rep_dec)
                    tcnt_d = '0;
                else if (tick) begin
                    if (tcnt_q == TW'(TIMEOUT_TICKS - 1)) begin
                        state_d = ST_RUN;
                        tcnt_d  = '0;
                    end else
                        tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
        edit_next = state_d == ST_EDIT_H || state_d == ST_EDIT_M || state_d == ST_EDIT_S;
        blink_d   = edit_next ? blink_q ^ tick : 1'b0;
    end

    // state, edit and edge registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            set_h_q   <= '0;
            set_m_q   <= '0;
            set_s_q   <= '0;
            tcnt_q    <= '0;
            blink_q   <= 1'b0;
            btn_set_q <= 1'b0;
            btn_inc_q <= 1'b0;
            btn_dec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_h_q   <= set_h_d;
            set_m_q   <= set_m_d;
            set_s_q   <= set_s_d;
            tcnt_q    <= tcnt_d;
            blink_q   <= blink_d;
            btn_set_q <= btn_set;
            btn_inc_q <= btn_inc;
            btn_dec_q <= btn_dec;
        end
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench; expected presets are queued and popped on each load strobe
module tb_clock_set_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, mode = 1'b0;
    logic       btn_set = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [5:0] cur_s = '0, cur_m = '0;
    logic [4:0] cur_h = '0;
    logic [5:0] set_s, set_m;
    logic [4:0] set_h;
    logic       load, editing, blink;
    logic [1:0] field;
    int         n_chk = 0, n_err = 0, load_cnt = 0;
    logic [16:0] sb_q[$];
    logic [16:0] exp_v;

    clock_set_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .mode(mode),
        .btn_set(btn_set), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_s(cur_s), .cur_m(cur_m), .cur_h(cur_h),
        .set_s(set_s), .set_m(set_m), .set_h(set_h),
        .load(load), .editing(editing), .field(field), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic s, input logic i, input logic d, input logic t);
        @(negedge clk);
        {btn_set, btn_inc, btn_dec, tick} = {s, i, d, t};
        @(negedge clk);
        {btn_set, btn_inc, btn_dec, tick} = 4'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic enter(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_h = h;
        cur_m = m;
        cur_s = s;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (load) begin
            load_cnt++;
            if (sb_q.size() == 0)
                chk("load_unexpected", 32'd1, 32'd0);
            else begin
                exp_v = sb_q.pop_front();
                chk("load_preset", {15'd0, set_h, set_m, set_s}, {15'd0, exp_v});
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_editing", editing, 0);
        chk("rst_load", load, 0);
        reset = 1'b1;
        @(negedge clk);

        enter(5'd14, 6'd30, 6'd5);
        chk("cap_field", field, 1);
        chk("cap_h", set_h, 14);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        chk("main_field_sec", field, 3);
        sb_q.push_back({5'd16, 6'd29, 6'd5});
        pulse(1, 0, 0, 0);
        chk("main_load", load, 1);
        @(negedge clk);
        chk("main_load_one", load, 0);
        chk("main_run", editing, 0);
        chk("main_hold_h", set_h, 16);
        chk("main_load_cnt", load_cnt, 1);

        enter(5'd23, 6'd0, 6'd7);
        pulse(0, 1, 0, 0);
        chk("wrap_h23", set_h, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        chk("wrap_m0", set_m, 59);
        pulse(1, 0, 0, 0);
        sb_q.push_back({5'd0, 6'd59, 6'd7});
        pulse(1, 0, 0, 0);
        @(negedge clk);
        chk("wrap_load_cnt", load_cnt, 2);

        mode = 1'b1;
        enter(5'd15, 6'd1, 6'd2);
        chk("h12_capture", set_h, 3);
        repeat (4) pulse(0, 0, 1, 0);
        chk("h12_dec_wrap", set_h, 11);
        pulse(0, 1, 0, 0);
        chk("h12_inc_wrap", set_h, 0);
        ticks(9);
        chk("to_still_edit", editing, 1);
        chk("to_blink", blink, 1);
        ticks(1);
        chk("to_editing", editing, 0);
        chk("to_field", field, 0);
        chk("to_blink_off", blink, 0);
        chk("to_no_load", load_cnt, 2);

        mode = 1'b0;
        enter(5'd10, 6'd20, 6'd30);
        pulse(0, 1, 1, 0);
        chk("incdec_h", set_h, 10);
        pulse(1, 1, 0, 0);
        chk("setinc_field", field, 2);
        chk("setinc_h", set_h, 10);
        ticks(3);
        pulse(0, 1, 0, 1);
        chk("tickpress_m", set_m, 21);
        ticks(9);
        chk("tickpress_cleared", editing, 1);
        ticks(1);
        chk("tickpress_timeout", editing, 0);

        enter(5'd5, 6'd10, 6'd0);
        pulse(1, 0, 0, 0);
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (800) @(negedge clk);
        btn_inc = 1'b0;
        @(negedge clk);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        chk("hold_inc_m", set_m, 14);
`else
        chk("hold_inc_m", set_m, 11);
`endif
        ticks(10);
        chk("hold_timeout", editing, 0);

        enter(5'd20, 6'd0, 6'd0);
        chk("clamp_pre", set_h, 20);
        @(negedge clk);
        mode = 1'b1;
        @(negedge clk);
        chk("clamp_h", set_h, 0);
        pulse(0, 1, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_editing", editing, 0);
        chk("rst_mid_field", field, 0);
        chk("rst_mid_set", {set_h, set_m, set_s}, 0);
        chk("rst_mid_blink", blink, 0);
        reset = 1'b1;
        mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_load", load_cnt, 2);
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
